// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern sequencer: step modes, bounce direction
// and the power-on pattern.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_ROT_L  = 2'b00,
    MODE_ROT_R  = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } led_mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } led_dir_e;

  // Low five LEDs lit after reset; widened to the LED bank by the top level.
  localparam logic [4:0] INIT_PATTERN_LOW = 5'b1_1111;

endpackage

// File: rtl/led_tick_gen.sv
// Step divider: raises tick for the cycle in which the counter has reached the
// effective period minus one; period 0 falls back to CLK_FREQ.
module led_tick_gen #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int DIV_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] p_eff;
  logic [DIV_WIDTH-1:0] cnt;

  assign p_eff = (period == '0) ? DIV_WIDTH'(CLK_FREQ) : period;

  // >= rather than == so shrinking the period below cnt steps at once instead
  // of wrapping through the whole counter range.
  assign tick = enable && (cnt >= (p_eff - DIV_WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern engine: rotates, bounces or holds an LED bank once per
// runtime-selectable step period, with load and freeze control.
module led_pattern_sequencer
  import led_pkg::*;
#(
  parameter int                   CLK_FREQ     = 25_000_000,
  parameter int                   LED_WIDTH    = 8,
  parameter int                   DIV_WIDTH    = 32,
  parameter logic [LED_WIDTH-1:0] INIT_PATTERN = LED_WIDTH'(INIT_PATTERN_LOW)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] period,
  input  logic                 load,
  input  logic [LED_WIDTH-1:0] load_pattern,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 step_pulse
);

  localparam int POS_W = $clog2(LED_WIDTH);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(LED_WIDTH - 1);

  logic             tick;
  logic [1:0]       mode_p1;
  logic             entering;
  logic [POS_W-1:0] pos, pos_cur;
  led_dir_e         dir, dir_cur;

  function automatic logic [LED_WIDTH-1:0] rot_left(input logic [LED_WIDTH-1:0] x);
    return {x[LED_WIDTH-2:0], x[LED_WIDTH-1]};
  endfunction

  function automatic logic [LED_WIDTH-1:0] rot_right(input logic [LED_WIDTH-1:0] x);
    return {x[0], x[LED_WIDTH-1:1]};
  endfunction

  led_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable),
    .clear (load),
    .period(period),
    .tick  (tick)
  );

  // Entering bounce restarts from the left edge; a step on that same edge
  // already uses the cleared position and direction.
  assign entering = (mode == MODE_BOUNCE) && (mode_p1 != MODE_BOUNCE);
  assign pos_cur  = entering ? '0 : pos;
  assign dir_cur  = entering ? DIR_LEFT : dir;

  always_ff @(posedge clk) begin
    mode_p1 <= mode;
    if (!rst_n) begin
      leds       <= INIT_PATTERN;
      step_pulse <= 1'b0;
      pos        <= '0;
      dir        <= DIR_LEFT;
    end else if (load) begin
      leds       <= load_pattern;
      step_pulse <= 1'b0;
      pos        <= '0;
      dir        <= DIR_LEFT;
    end else begin
      step_pulse <= tick;
      pos        <= pos_cur;
      dir        <= dir_cur;
      if (tick) begin
        case (led_mode_e'(mode))
          MODE_ROT_L: leds <= rot_left(leds);
          MODE_ROT_R: leds <= rot_right(leds);
          MODE_BOUNCE: begin
            if (dir_cur == DIR_LEFT) begin
              leds <= rot_left(leds);
              pos  <= pos_cur + POS_W'(1);
              if (pos_cur == POS_LAST - POS_W'(1)) dir <= DIR_RIGHT;
            end else begin
              leds <= rot_right(leds);
              pos  <= pos_cur - POS_W'(1);
              if (pos_cur == POS_W'(1)) dir <= DIR_LEFT;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed scenarios plus a randomized run,
// all compared every cycle against a step-count based reference model.
module tb_led_pattern_sequencer;

  localparam int W    = 8;
  localparam int FREQ = 16;
  localparam int DW   = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [DW-1:0] period = '0;
  logic          load = 1'b0;
  logic [W-1:0]  load_pattern = '0;
  logic [W-1:0]  leds;
  logic          step_pulse;

  int checks = 0;
  int errors = 0;

  // Reference model state: divider count, pattern, pulse, bounce steps taken.
  int           m_cnt = 0;
  logic [W-1:0] m_leds = '0;
  logic         m_pulse = 1'b0;
  int           m_b = 0;
  logic [1:0]   m_mode_prev = 2'b00;

  always #5 clk = ~clk;

  led_pattern_sequencer #(
    .CLK_FREQ (FREQ),
    .LED_WIDTH(W),
    .DIV_WIDTH(DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .mode        (mode),
    .period      (period),
    .load        (load),
    .load_pattern(load_pattern),
    .leds        (leds),
    .step_pulse  (step_pulse)
  );

  function automatic logic [W-1:0] m_rotl(input logic [W-1:0] x);
    return W'((int'(x) * 2) % (1 << W) + int'(x) / (1 << (W - 1)));
  endfunction

  function automatic logic [W-1:0] m_rotr(input logic [W-1:0] x);
    return W'(int'(x) / 2 + (int'(x) % 2) * (1 << (W - 1)));
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance the model with the inputs as they stand, clock once, compare.
  task automatic cycle(input string tag);
    int p;
    bit step;
    p    = (period == 0) ? FREQ : int'(period);
    step = enable && (m_cnt >= p - 1);
    if (!rst_n) begin
      m_leds = 8'h1F; m_cnt = 0; m_pulse = 0; m_b = 0;
    end else if (load) begin
      m_leds = load_pattern; m_cnt = 0; m_pulse = 0; m_b = 0;
    end else begin
      if (mode == 2'b10 && m_mode_prev != 2'b10) m_b = 0;
      m_pulse = step;
      if (enable) m_cnt = step ? 0 : m_cnt + 1;
      if (step) begin
        case (mode)
          2'b00: m_leds = m_rotl(m_leds);
          2'b01: m_leds = m_rotr(m_leds);
          2'b10: begin
            // Bounce: W-1 steps left, then W-1 steps right, repeating.
            if ((m_b % (2 * (W - 1))) < (W - 1)) m_leds = m_rotl(m_leds);
            else m_leds = m_rotr(m_leds);
            m_b++;
          end
          default: ;
        endcase
      end
    end
    m_mode_prev = mode;
    @(posedge clk);
    #1;
    check({tag, ".leds"}, leds, m_leds);
    check({tag, ".pulse"}, W'(step_pulse), W'(m_pulse));
  endtask

  task automatic do_load(input logic [W-1:0] pat, input logic [1:0] md, input int per);
    load = 1'b1; load_pattern = pat; mode = md; period = DW'(per);
    cycle("load");
    load = 1'b0;
  endtask

  initial begin
    logic [W-1:0] bounce_exp [15];
    logic [W-1:0] frozen;
    int pulses;
    int guard;

    bounce_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                   8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    // Reset then rotate left at period 4
    rst_n = 1'b0; period = 4; mode = 2'b00; enable = 1'b1;
    cycle("reset");
    cycle("reset");
    check("reset_leds", leds, 8'h1F);
    check("reset_pulse", W'(step_pulse), 8'h00);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cycle("rotl");
      if (i == 4) begin check("rotl_4", leds, 8'h3E); check("rotl_4p", W'(step_pulse), 8'h01); end
      if (i == 8) begin check("rotl_8", leds, 8'h7C); check("rotl_8p", W'(step_pulse), 8'h01); end
    end

    // Rotate right at period 2
    do_load(8'h01, 2'b01, 2);
    for (int i = 1; i <= 6; i++) begin
      cycle("rotr");
      if (i == 2) check("rotr_1", leds, 8'h80);
      if (i == 4) check("rotr_2", leds, 8'h40);
      if (i == 6) check("rotr_3", leds, 8'h20);
    end

    // Bounce at period 1
    do_load(8'h01, 2'b10, 1);
    for (int i = 0; i < 15; i++) begin
      cycle("bounce");
      check($sformatf("bounce_%0d", i), leds, bounce_exp[i]);
    end

    // Load on the step cycle, then freeze
    mode = 2'b00; period = 5;
    guard = 0;
    while (m_cnt != 4 && guard < 20) begin cycle("pre_load"); guard++; end
    checks++;
    assert (guard < 20) else begin errors++; $error("FAIL load_align: observed %0d expected <20", guard); end
    do_load(8'hA5, 2'b00, 5);
    check("load_a5", leds, 8'hA5);
    check("load_nopulse", W'(step_pulse), 8'h00);
    for (int i = 1; i <= 5; i++) cycle("after_load");
    check("after_load_step", leds, 8'h4B);
    check("after_load_pulse", W'(step_pulse), 8'h01);
    cycle("pre_freeze");
    cycle("pre_freeze");
    frozen = leds;
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle("frozen");
      check("frozen_leds", leds, frozen);
    end
    enable = 1'b1;
    for (int i = 0; i < 3; i++) cycle("resume");
    check("resume_step", W'(step_pulse), 8'h01);

    // Period edge cases
    do_load(8'h01, 2'b00, 100);
    for (int i = 0; i < 50; i++) cycle("p100");
    period = 10;
    cycle("p10");
    check("shrink_step", W'(step_pulse), 8'h01);
    period = 1;
    for (int i = 0; i < 5; i++) begin
      cycle("p1");
      check("p1_pulse", W'(step_pulse), 8'h01);
    end
    period = 0;
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      cycle("p0");
      if (step_pulse === 1'b1) pulses++;
    end
    check("p0_pulses", W'(pulses), 8'd2);

    // Reset while bouncing rightwards
    do_load(8'h01, 2'b10, 1);
    for (int i = 0; i < 8; i++) cycle("bounce_pre");
    check("bounce_right", leds, 8'h40);
    rst_n = 1'b0;
    cycle("mid_reset");
    check("mid_reset_leds", leds, 8'h1F);
    rst_n = 1'b1;
    cycle("post_reset");
    check("post_reset_left", leds, 8'h3E);

    // Randomized run
    for (int i = 0; i < 600; i++) begin
      rst_n        = ($urandom_range(0, 99) >= 2);
      load         = ($urandom_range(0, 99) < 5);
      load_pattern = W'($urandom);
      enable       = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 29) == 0) period = DW'($urandom_range(0, 6));
      cycle("random");
    end
    load = 1'b0;
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
